seq_detect_sched: RTL and testbench

SEQ_DETECT_SCHED -- requirements
Module: seq_detect_sched

---
 rtl/seq_sched_pkg.sv | 22 ++
 rtl/seq_next_state.sv | 23 ++
 rtl/seq_detect_sched.sv | 97 +++++++++
 tb/tb_seq_detect_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the time-shared sequence detector.
// The state encodings are fixed because saved states are visible in the history registers.
package seq_sched_pkg;

  localparam int unsigned NCH_DEFAULT = 4;
  localparam int unsigned ST_W        = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_A = 3'd0;
  localparam state_t ST_B = 3'd1;
  localparam state_t ST_C = 3'd2;
  localparam state_t ST_D = 3'd3;
  localparam state_t ST_E = 3'd4;
  localparam state_t ST_F = 3'd5;

  // Detect flag: only E and F count, so illegal encodings read as 0.
  function automatic logic is_detect(input state_t s);
    return (s == ST_E) || (s == ST_F);
  endfunction

endpackage

// File: rtl/seq_next_state.sv
// Six-state transition table shared by all channels; illegal encodings recover to A.
module seq_next_state
  import seq_sched_pkg::*;
(
  input  state_t cur,
  input  logic   w,
  output state_t nxt_c
);

  always_comb begin
    nxt_c = ST_A;
    case (cur)
      ST_A:    nxt_c = w ? ST_A : ST_B;
      ST_B:    nxt_c = w ? ST_D : ST_C;
      ST_C:    nxt_c = w ? ST_D : ST_E;
      ST_D:    nxt_c = w ? ST_A : ST_F;
      ST_E:    nxt_c = w ? ST_D : ST_E;
      ST_F:    nxt_c = w ? ST_D : ST_C;
      default: nxt_c = ST_A;
    endcase
  end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that time-shares one detector across NCH channels,
// keeping a saved state per channel and updating only the granted one.
module seq_detect_sched
  import seq_sched_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] req_valid,
  input  logic [NCH-1:0] req_w,
  input  logic [NCH-1:0] clr,
  output logic [NCH-1:0] req_ready,
  output logic [NCH-1:0] z,
  output logic [NCH-1:0] z_valid,
  output logic           busy
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t         st_q [NCH];
  logic [PW-1:0]  ptr_q;
  logic [NCH-1:0] zv_q;

  logic [NCH-1:0] elig_c;
  logic [NCH-1:0] grant_c;
  logic [PW-1:0]  gidx_c;
  logic           any_c;
  state_t         cur_c;
  state_t         nxt_c;
  logic           w_c;

  // Cleared channels never compete; nothing is granted while reset holds.
  assign elig_c = req_valid & ~clr & {NCH{~reset}};

  // First eligible channel at or after ptr, wrapping modulo NCH.
  always_comb begin
    logic [PW:0] idx;
    any_c  = 1'b0;
    gidx_c = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NCH)) idx = idx - (PW+1)'(NCH);
      if (!any_c && elig_c[idx[PW-1:0]]) begin
        any_c  = 1'b1;
        gidx_c = idx[PW-1:0];
      end
    end
  end

  assign grant_c   = any_c ? (NCH'(1) << gidx_c) : '0;
  assign req_ready = grant_c;
  assign busy      = |req_valid;

  assign cur_c = st_q[gidx_c];
  assign w_c   = req_w[gidx_c];

  seq_next_state u_next (
    .cur   (cur_c),
    .w     (w_c),
    .nxt_c (nxt_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (any_c) begin
      ptr_q <= (32'(gidx_c) == NCH - 1) ? '0 : gidx_c + PW'(1);
    end
  end

  // Clear wins over a sample; the arbiter already excludes cleared channels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) st_q[i] <= ST_A;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (clr[i])          st_q[i] <= ST_A;
        else if (grant_c[i]) st_q[i] <= nxt_c;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) zv_q <= '0;
    else       zv_q <= grant_c;
  end

  assign z_valid = zv_q;

  always_comb begin
    z = '0;
    for (int unsigned i = 0; i < NCH; i++) z[i] = is_detect(st_q[i]);
  end

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench: directed vector table, hand sequences and random traffic
// compared against a table-lookup model of the per-channel detectors.
module tb_seq_detect_sched;

  localparam int NCH = 4;

  logic           clk;
  logic           reset;
  logic [NCH-1:0] req_valid, req_w, clr;
  logic [NCH-1:0] req_ready, z, z_valid;
  logic           busy;

  seq_detect_sched #(.NCH(NCH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_w     (req_w),
    .clr       (clr),
    .req_ready (req_ready),
    .z         (z),
    .z_valid   (z_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: next-state lookup indexed [state][w].
  int nxt_tab [6][2] = '{'{1, 0}, '{2, 3}, '{4, 3}, '{5, 0}, '{4, 3}, '{2, 3}};
  int m_st [NCH];
  int m_ptr;
  logic [NCH-1:0] m_zv;

  typedef struct {
    bit             rst;
    logic [NCH-1:0] vld, w, c, rdy, ez, ezv;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NCH-1:0] m_grant(input logic [NCH-1:0] v, input logic [NCH-1:0] c);
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_ptr + k) % NCH;
      if (v[idx] && !c[idx]) return NCH'(1) << idx;
    end
    return '0;
  endfunction

  function automatic logic [NCH-1:0] m_z();
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (m_st[i] == 4) || (m_st[i] == 5);
    return r;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NCH; i++) m_st[i] = 0;
    m_ptr = 0;
    m_zv  = '0;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input logic [NCH-1:0] v, input logic [NCH-1:0] w, input logic [NCH-1:0] c,
                       input bit use_tbl, input logic [NCH-1:0] er, input logic [NCH-1:0] ez,
                       input logic [NCH-1:0] ezv);
    logic [NCH-1:0] g;
    req_valid = v; req_w = w; clr = c;
    g = m_grant(v, c);
    #4;
    chk("req_ready", req_ready, use_tbl ? er : g);
    n_chk++;
    if (busy !== (|v)) begin
      n_fail++;
      $display("FAIL busy: got %b expected %b at %0t", busy, |v, $time);
    end
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (c[i])      m_st[i] = 0;
      else if (g[i]) m_st[i] = nxt_tab[m_st[i]][w[i]];
      if (g[i])      m_ptr = (i + 1) % NCH;
    end
    m_zv = g;
    #1;
    chk("z", z, use_tbl ? ez : m_z());
    chk("z_valid", z_valid, use_tbl ? ezv : m_zv);
  endtask

  // Mid-cycle asynchronous reset with traffic presented while it is held.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    req_valid = NCH'($urandom);
    req_w     = NCH'($urandom);
    clr       = '0;
    m_reset();
    #1;
    chk("z_on_reset", z, '0);
    chk("z_valid_on_reset", z_valid, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("z_valid_after_reset_edges", z_valid, '0);
    reset = 1'b0;
    req_valid = '0;
    req_w     = '0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_w = '0; clr = '0;
    m_reset();
    #1;
    chk("reset_z", z, '0);
    chk("reset_z_valid", z_valid, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin with all channels requesting, then channel 0 alone through B,C,E,D,F.
    tbl.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010});
    tbl.push_back('{1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001});
    tbl.push_back('{1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].vld, tbl[i].w, tbl[i].c, 1'b1, tbl[i].rdy, tbl[i].ez, tbl[i].ezv);
    end

    // Clear and sample on channel 2 together: channel 3 wins, channel 2 back to A.
    do_reset();
    repeat (3) apply(4'b0100, 4'b0000, 4'b0000, 1'b0, '0, '0, '0);
    chk("ch2_detect_before_clr", z, 4'b0100);
    apply(4'b1100, 4'b0000, 4'b0100, 1'b1, 4'b1000, 4'b0000, 4'b1000);
    repeat (3) apply(4'b0100, 4'b0000, 4'b0000, 1'b0, '0, '0, '0);
    chk("ch2_restart_from_a", z, 4'b0100);

    // Interleaved channels 0 and 1.
    do_reset();
    repeat (6) apply(4'b0011, 4'b0010, 4'b0000, 1'b0, '0, '0, '0);
    chk("interleave_z", z, 4'b0001);

    // Asynchronous reset while z[0] is high, then channel 0 restarts from A.
    do_reset();
    repeat (2) apply(4'b0001, 4'b0000, 4'b0000, 1'b0, '0, '0, '0);
    chk("ch0_not_yet_detect", z, 4'b0000);
    apply(4'b0001, 4'b0000, 4'b0000, 1'b0, '0, '0, '0);
    chk("ch0_restart_detect", z, 4'b0001);

    // Random traffic with sparse clears and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [NCH-1:0] v, w, c;
      if (i % 150 == 149) do_reset();
      v = NCH'($urandom);
      w = NCH'($urandom);
      c = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      apply(v, w, c, 1'b0, '0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
